// File: rtl/result_collector_pkg.sv
// Shared types and widths for the result collector slice.
package result_collector_pkg;

    localparam int unsigned RESULT_W   = 32;
    localparam int unsigned DROP_CNT_W = 16;

    typedef logic [RESULT_W-1:0] result_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO: storage, extended-bit pointers, full/empty and level.
module sync_fifo_fwft
    import result_collector_pkg::*;
#(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned DATA_W = RESULT_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr_i,
    input  logic                    push_i,
    input  logic                    pop_i,
    input  logic [DATA_W-1:0]       data_i,
    output logic [DATA_W-1:0]       data_o,
    output logic                    empty_o,
    output logic                    full_o,
    output logic [$clog2(DEPTH):0]  level_o
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW:0]       wr_q;
    logic [AW:0]       wr_d;
    logic [AW:0]       rd_q;
    logic [AW:0]       rd_d;

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (clr_i) begin
            wr_d = '0;
            rd_d = '0;
        end else begin
            if (push_i) begin
                wr_d = wr_q + PTR_ONE;
            end
            if (pop_i) begin
                rd_d = rd_q + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage is not reset; the head is masked to zero while empty instead.
    always_ff @(posedge clk) begin
        if (push_i && !clr_i) begin
            mem_q[wr_q[AW-1:0]] <= data_i;
        end
    end

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign level_o = wr_q - rd_q;
    assign data_o  = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

endmodule

// File: rtl/result_collector.sv
// Buffers unstallable datapath results for a valid/ready consumer, flags drops.
// Optional drop counter enabled by defining RESULT_COLLECTOR_DROP_CNT_EN.
module result_collector
    import result_collector_pkg::*;
#(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned DATA_W = RESULT_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_W-1:0]       data_i,
    input  logic                    valid_i,
    input  logic                    clr_i,
    output logic [DATA_W-1:0]       data_o,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic [$clog2(DEPTH):0]  level_o,
    output logic                    ovf_o
`ifdef RESULT_COLLECTOR_DROP_CNT_EN
    ,
    output logic [DROP_CNT_W-1:0]   drop_cnt_o
`endif
);

    logic empty;
    logic full;
    logic push;
    logic pop;
    logic drop;

    // Clear wins over both handshakes; a full FIFO still accepts when popping.
    assign pop  = valid_o && ready_i && !clr_i;
    assign push = valid_i && (!full || pop) && !clr_i;
    assign drop = valid_i && full && !pop && !clr_i;

    assign valid_o = !empty;

    sync_fifo_fwft #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (clr_i),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (data_i),
        .data_o  (data_o),
        .empty_o (empty),
        .full_o  (full),
        .level_o (level_o)
    );

`ifdef RESULT_COLLECTOR_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] drop_cnt_q;
    logic [DROP_CNT_W-1:0] drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (clr_i) begin
            drop_cnt_d = '0;
        end else if (drop && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + {{(DROP_CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt_o = drop_cnt_q;
    assign ovf_o      = (drop_cnt_q != '0);
`else
    logic ovf_q;
    logic ovf_d;

    always_comb begin
        ovf_d = ovf_q;
        if (clr_i) begin
            ovf_d = 1'b0;
        end else if (drop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf_o = ovf_q;
`endif

endmodule

// File: tb/tb_result_collector.sv
// Scoreboard bench for result_collector: a queue model checked every falling edge.
module tb_result_collector;

    localparam int unsigned DEPTH  = 8;
    localparam int unsigned DATA_W = 32;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [DATA_W-1:0]      data_i;
    logic                   valid_i;
    logic                   clr_i;
    logic [DATA_W-1:0]      data_o;
    logic                   valid_o;
    logic                   ready_i;
    logic [$clog2(DEPTH):0] level_o;
    logic                   ovf_o;
`ifdef RESULT_COLLECTOR_DROP_CNT_EN
    logic [15:0]            drop_cnt_o;
`endif

    result_collector #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data_i     (data_i),
        .valid_i    (valid_i),
        .clr_i      (clr_i),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .level_o    (level_o),
        .ovf_o      (ovf_o)
`ifdef RESULT_COLLECTOR_DROP_CNT_EN
        ,
        .drop_cnt_o (drop_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model state describes the DUT after the next rising edge.
    logic [31:0] sb[$];
    int unsigned m_level = 0;
    logic        m_ovf   = 1'b0;
    int unsigned m_cnt   = 0;
    logic        m_pop;
    logic        m_push;
    logic        m_drop;

    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            m_level = 0;
            m_ovf   = 1'b0;
            m_cnt   = 0;
        end else begin
            check("valid_o", {31'b0, valid_o}, {31'b0, m_level != 0});
            check("level_o", 32'(level_o), m_level);
            check("ovf_o", {31'b0, ovf_o}, {31'b0, m_ovf});
`ifdef RESULT_COLLECTOR_DROP_CNT_EN
            check("drop_cnt_o", {16'b0, drop_cnt_o}, m_cnt);
`endif
            if (m_level != 0) check("data_o", data_o, sb[0]);
            else              check("data_o_empty", data_o, 32'h0);

            m_pop  = (m_level != 0) && ready_i && !clr_i;
            m_push = valid_i && ((m_level < DEPTH) || m_pop) && !clr_i;
            m_drop = valid_i && !m_push && !clr_i;
            if (clr_i) begin
                sb.delete();
                m_ovf = 1'b0;
                m_cnt = 0;
            end else begin
                if (m_pop)  void'(sb.pop_front());
                if (m_push) sb.push_back(data_i);
                if (m_drop) begin
                    m_ovf = 1'b1;
                    if (m_cnt < 32'hFFFF) m_cnt++;
                end
            end
            m_level = sb.size();
        end
    end

    task automatic cyc(input logic v, input logic [31:0] d, input logic r, input logic c);
        valid_i = v;
        data_i  = d;
        ready_i = r;
        clr_i   = c;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0);
    endtask

    int unsigned pushed;
    int unsigned guard;
    logic        v;
    logic        r;

    initial begin
        rst = 1'b1; valid_i = 1'b0; data_i = '0; ready_i = 1'b0; clr_i = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check("rst_valid", {31'b0, valid_o}, 32'h0);
        check("rst_level", 32'(level_o), 32'h0);
        check("rst_ovf",   {31'b0, ovf_o}, 32'h0);
        check("rst_data",  data_o, 32'h0);
        rst = 1'b0;
        cyc(1'b0, 32'h0, 1'b0, 1'b0);

        // Single push with idle consumer.
        cyc(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
        for (int unsigned i = 0; i < 3; i++) begin
            check("single_valid", {31'b0, valid_o}, 32'h1);
            check("single_data", data_o, 32'hDEAD_BEEF);
            check("single_level", 32'(level_o), 32'h1);
            cyc(1'b0, 32'h0, 1'b0, 1'b0);
        end
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        check("single_popped", {31'b0, valid_o}, 32'h0);

        // Fill and overflow.
        for (int unsigned i = 1; i <= 9; i++) cyc(1'b1, i, 1'b0, 1'b0);
        check("fill_level", 32'(level_o), 32'h8);
        check("fill_ovf", {31'b0, ovf_o}, 32'h1);
        drain(10);
        check("fill_drained", 32'(level_o), 32'h0);
        check("ovf_sticky", {31'b0, ovf_o}, 32'h1);
        cyc(1'b0, 32'h0, 1'b0, 1'b1);
        check("ovf_cleared", {31'b0, ovf_o}, 32'h0);

        // Full with simultaneous pop.
        for (int unsigned i = 0; i < 8; i++) cyc(1'b1, 32'h100 + i, 1'b0, 1'b0);
        cyc(1'b1, 32'h55, 1'b1, 1'b0);
        check("fullpop_level", 32'(level_o), 32'h8);
        check("fullpop_ovf", {31'b0, ovf_o}, 32'h0);
        drain(9);

        // Random streaming with wrap-around.
        pushed = 0;
        guard  = 0;
        while (pushed < 40 && guard < 2000) begin
            v = ($urandom_range(0, 1) == 1);
            r = ($urandom_range(0, 9) < 7) || (m_level >= DEPTH - 1);
            if (v) pushed++;
            cyc(v, $urandom, r, 1'b0);
            guard++;
        end
        check("stream_pushes", pushed, 32'd40);
        drain(10);
        check("stream_ovf", {31'b0, ovf_o}, 32'h0);
        check("stream_empty", 32'(level_o), 32'h0);

        // Clear beats push and pop.
        for (int unsigned i = 0; i < 5; i++) cyc(1'b1, 32'h200 + i, 1'b0, 1'b0);
        check("clr_pre_level", 32'(level_o), 32'h5);
        cyc(1'b1, 32'hA5, 1'b1, 1'b1);
        check("clr_level", 32'(level_o), 32'h0);
        check("clr_valid", {31'b0, valid_o}, 32'h0);
        check("clr_ovf", {31'b0, ovf_o}, 32'h0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);

        // Asynchronous reset mid-stream at level 3 with overflow set.
        for (int unsigned i = 1; i <= 9; i++) cyc(1'b1, 32'h300 + i, 1'b0, 1'b0);
        for (int unsigned i = 0; i < 5; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0);
        check("pre_rst_level", 32'(level_o), 32'h3);
        check("pre_rst_ovf", {31'b0, ovf_o}, 32'h1);
        #1 rst = 1'b1;
        #1;
        check("arst_valid", {31'b0, valid_o}, 32'h0);
        check("arst_level", 32'(level_o), 32'h0);
        check("arst_ovf",   {31'b0, ovf_o}, 32'h0);
        check("arst_data",  data_o, 32'h0);
`ifdef RESULT_COLLECTOR_DROP_CNT_EN
        check("arst_drop_cnt", {16'b0, drop_cnt_o}, 32'h0);
`endif
        @(negedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // Sanity after reset.
        cyc(1'b1, 32'h1234_5678, 1'b0, 1'b0);
        check("post_rst_data", data_o, 32'h1234_5678);
        drain(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/result_collector.md
Name: result_collector

Overview:
Downstream stage of the register/ALU datapath. It captures each 32-bit result that the datapath emits with a one-cycle valid strobe, and the datapath cannot be stalled. Results are buffered in a first-word-fall-through FIFO and delivered to a consumer over a valid/ready handshake. Full-FIFO drops are flagged, and a FIFO fill level is reported for monitoring.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- DATA_W, 32, result width; equals the datapath output width.

Ports:
- clk  input  1  single clock.
- rst  input  1  asynchronous, active-high reset.
- data_i  input  DATA_W  result from the datapath.
- valid_i  input  1  one-cycle strobe: data_i is valid this cycle. There is no backpressure.
- clr_i  input  1  synchronous flush.
- data_o  output  DATA_W  FIFO head.
- valid_o  output  1  FIFO not empty.
- ready_i  input  1  consumer accepts the head this cycle.
- level_o  output  $clog2(DEPTH)+1  number of stored entries.
- ovf_o  output  1  sticky: at least one result has been dropped.

Behaviour:
- Reset (asynchronous, rst=1):
  - Pointers are zero; level_o=0, valid_o=0, ovf_o=0.
  - data_o is driven to 0 while the FIFO is empty (it is not X).
- push = valid_i && (!full || pop).
- pop = valid_o && ready_i.
- A push writes data_i at the write pointer. Both pointers wrap modulo DEPTH.
- Full/empty are distinguished by one extra pointer bit.
- Latency: a push into an empty FIFO makes valid_o=1 with data_o=data_i on the next rising edge. There is no combinational path from valid_i to valid_o.
- FWFT: data_o always shows mem[rd_ptr]. It stays stable while valid_o=1 and ready_i=0.
- Simultaneous push and pop:
  - Both are accepted and the level is unchanged.
  - This holds when full: the entry freed by the pop is reused, so nothing is dropped.
  - When empty, a push-and-pop cycle is not a bypass: the popped item does not exist yet, so pop=0.
- Full, valid_i=1, no pop: data_i is discarded, ovf_o is set, and the FIFO contents are untouched.
- ovf_o stays set until clr_i or rst.
- clr_i=1:
  - Next edge: pointers=0, level=0, ovf_o=0.
  - clr_i beats push and pop in the same cycle: the valid_i data in that cycle is discarded and not counted as a drop.
- ready_i while empty is ignored.
- Reset mid-operation: all contents are lost immediately; outputs take their reset values asynchronously.
- level_o = wr_ptr - rd_ptr. Width arithmetic uses the extended pointer bits and never saturates beyond DEPTH.

Optional Feature:
- Macro: RESULT_COLLECTOR_DROP_CNT_EN.
- Defined:
  - Adds output port drop_cnt_o, 16 bits.
  - It increments on every discarded push and saturates at 16'hFFFF.
  - It clears on rst or clr_i.
  - ovf_o = (drop_cnt_o != 0).
- Undefined: the port and counter are absent, and ovf_o is a single sticky flop.

Decomposition:
- Package result_collector_pkg holds:
  - localparam RESULT_W = 32;
  - typedef logic [RESULT_W-1:0] result_t;
  - the drop-counter width constant DROP_CNT_W = 16.
- One natural sub-module, sync_fifo_fwft, holding the storage, pointers, full/empty and level.
- result_collector wraps sync_fifo_fwft and adds the push gating, clear priority and overflow/drop logic.

Test Plan:
- Single push, idle consumer:
  - valid_i pulse with data_i=32'hDEAD_BEEF, ready_i=0.
  - Next cycle: valid_o=1, data_o=DEADBEEF, level_o=1.
  - Holds until ready_i=1; then valid_o=0 the following cycle.
- Fill and overflow:
  - 9 back-to-back pushes of 1..9, ready_i=0.
  - level_o=8; ovf_o rises after the 9th push.
  - Drain yields 1..8 in order; 9 is absent.
- Full with simultaneous pop:
  - Fill with 8 values; then push 32'h55 while ready_i=1.
  - ovf_o stays 0 and level_o stays 8.
  - Final drained entry is 32'h55.
- Wrap-around streaming:
  - 40 pushes at a random 50% rate with ready_i random 70%.
  - Output order equals input order, with no drops and no ovf_o.
- Clear priority:
  - FIFO at level 5; assert clr_i together with valid_i=1 (data 32'hA5) and ready_i=1.
  - Next cycle: level_o=0, valid_o=0, ovf_o=0, and 32'hA5 is never output.
- Async reset mid-stream:
  - Assert rst between clock edges with level 3.
  - valid_o, level_o and ovf_o go to 0 before the next edge.
  - With RESULT_COLLECTOR_DROP_CNT_EN defined, drop_cnt_o also resets to 0.
